// File: rtl/mac_stop_seq.sv
// mac_stop_seq: drives the A/B read ports and the C write port of a matrix
// memory unit to compute C = A*B, one multiply-accumulate per cycle.
// A stop request aborts the run; a write already on the port completes.
// Build option: define MAC_STOP_SEQ_SIGNED_EN for two's-complement operands
// (signed product, sign-extended into the accumulator). Default is unsigned.
module mac_stop_seq #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                stop,
  output logic                                busy,
  output logic                                done,
  output logic                                stopped,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
  output logic [$clog2(M)-1:0]                row_addr_a,
  output logic [$clog2(K)-1:0]                col_addr_a,
  output logic [$clog2(K)-1:0]                row_addr_b,
  output logic [$clog2(N)-1:0]                col_addr_b,
  output logic [$clog2(M)-1:0]                row_addr_c,
  output logic [$clog2(N)-1:0]                col_addr_c,
  output logic                                matrix_a_re,
  output logic                                matrix_b_re,
  output logic                                matrix_c_we,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c
);

  localparam int IW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int JW = $clog2(N);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int PW = 2*DATA_WIDTH_INIT_MATRIX;
  localparam int RW = DATA_WIDTH_RESULT_MATRIX;

  localparam logic [IW-1:0] I_LAST = IW'(M-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
  localparam logic [JW-1:0] J_LAST = JW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] acc_q, acc_d;
  logic          stopped_q, stopped_d;

  // Full-width product of the operand pair currently on the read ports.
  // Operands are extended to PW bits first so the multiply is PW wide.
  logic [PW-1:0] prod;
  logic [RW-1:0] prod_ext;

`ifdef MAC_STOP_SEQ_SIGNED_EN
  logic signed [PW-1:0] prod_s;
  assign prod_s   = $signed({{DW{data_in_a[DW-1]}}, data_in_a})
                  * $signed({{DW{data_in_b[DW-1]}}, data_in_b});
  assign prod     = prod_s;
  // Sign-extend the product into the accumulator width.
  assign prod_ext = RW'(prod_s);
`else
  assign prod     = {{DW{1'b0}}, data_in_a} * {{DW{1'b0}}, data_in_b};
  // Zero-extend the product into the accumulator width.
  assign prod_ext = RW'(prod);
`endif

  // State, counters, accumulator and pulse register; synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      stopped_q <= stopped_d;
    end
  end

  // Next-state, counter walk and accumulate logic.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    stopped_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A simultaneous stop cancels the start without any pulse.
        if (start && !stop) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (stop) begin
          // Partial element is dropped; counters parked at zero.
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          acc_d     = '0;
          stopped_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          acc_d = (k_q == '0) ? prod_ext : (acc_q + prod_ext);
          if (k_q == K_LAST) begin
            state_d = S_WRITE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_WRITE: begin
        // The C write is on the port this cycle regardless of stop.
        k_d = '0;
        if (j_q == J_LAST) begin
          j_d = '0;
          i_d = (i_q == I_LAST) ? '0 : (i_q + IW'(1));
        end else begin
          j_d = j_q + JW'(1);
        end
        if (stop) begin
          i_d       = '0;
          j_d       = '0;
          stopped_d = 1'b1;
          state_d   = S_IDLE;
        end else if ((i_q == I_LAST) && (j_q == J_LAST)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-port and status outputs, decoded from state and counters.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    stopped     = stopped_q;
    row_addr_a  = '0;
    col_addr_a  = '0;
    row_addr_b  = '0;
    col_addr_b  = '0;
    row_addr_c  = '0;
    col_addr_c  = '0;
    matrix_a_re = 1'b0;
    matrix_b_re = 1'b0;
    matrix_c_we = 1'b0;
    data_out_c  = '0;
    unique case (state_q)
      S_MAC: begin
        busy        = 1'b1;
        matrix_a_re = 1'b1;
        matrix_b_re = 1'b1;
        row_addr_a  = i_q;
        col_addr_a  = k_q;
        row_addr_b  = k_q;
        col_addr_b  = j_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        matrix_c_we = 1'b1;
        row_addr_c  = i_q;
        col_addr_c  = j_q;
        data_out_c  = acc_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_stop_seq.sv
// Bench for mac_stop_seq at M=K=N=2: an event scoreboard (C writes, done and
// stopped pulses) filled by the stimulus, drained by a negedge monitor.
module tb_mac_stop_seq;

  localparam int M  = 2;
  localparam int K  = 2;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int RW = 2*DW + $clog2(K);

  localparam int EV_WRITE   = 0;
  localparam int EV_DONE    = 1;
  localparam int EV_STOPPED = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy, done, stopped;
  logic [DW-1:0] data_in_a, data_in_b;
  logic [0:0]    row_addr_a, col_addr_a, row_addr_b, col_addr_b;
  logic [0:0]    row_addr_c, col_addr_c;
  logic          matrix_a_re, matrix_b_re, matrix_c_we;
  logic [RW-1:0] data_out_c;

  logic [DW-1:0] mem_a [2][2];
  logic [DW-1:0] mem_b [2][2];

  typedef struct {
    int            kind;
    int            r;
    int            c;
    logic [RW-1:0] d;
  } ev_t;
  ev_t sbq[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_stop_seq #(
    .M(M), .K(K), .N(N),
    .DATA_WIDTH_INIT_MATRIX(DW),
    .DATA_WIDTH_RESULT_MATRIX(RW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .busy(busy), .done(done), .stopped(stopped),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
    .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
    .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
    .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re),
    .matrix_c_we(matrix_c_we), .data_out_c(data_out_c)
  );

  // Combinational-read memory model
  assign data_in_a = matrix_a_re ? mem_a[row_addr_a][col_addr_a] : '0;
  assign data_in_b = matrix_b_re ? mem_b[row_addr_b][col_addr_b] : '0;

  task automatic load(input logic [DW-1:0] a00, a01, a10, a11,
                      input logic [DW-1:0] b00, b01, b10, b11);
    mem_a[0][0] = a00; mem_a[0][1] = a01; mem_a[1][0] = a10; mem_a[1][1] = a11;
    mem_b[0][0] = b00; mem_b[0][1] = b01; mem_b[1][0] = b10; mem_b[1][1] = b11;
  endtask

  task automatic push(input int kind, input int r, input int c, input logic [RW-1:0] d);
    ev_t e;
    e.kind = kind; e.r = r; e.c = c; e.d = d;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT event is matched against the oldest expected event.
  task automatic observe(input int kind, input int r, input int c, input logic [RW-1:0] d);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d r=%0d c=%0d d=%0h required=none", kind, r, c, d);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || (kind == EV_WRITE && (e.r != r || e.c != c || e.d != d))) begin
        failures++;
        $display("FAIL event kind=%0d r=%0d c=%0d d=%0h required kind=%0d r=%0d c=%0d d=%0h",
                 kind, r, c, d, e.kind, e.r, e.c, e.d);
      end else begin
        $display("event ok kind=%0d r=%0d c=%0d d=%0h", kind, r, c, d);
      end
    end
    if (kind != EV_WRITE) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_during_pulse actual=%0b required=0", busy);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (matrix_c_we) observe(EV_WRITE, int'(row_addr_c), int'(col_addr_c), data_out_c);
      if (done)        observe(EV_DONE, 0, 0, '0);
      if (stopped)     observe(EV_STOPPED, 0, 0, '0);
    end
  end

  task automatic check_idle(input string name);
    logic [RW+11:0] v;
    @(negedge clk);
    v = {busy, done, stopped, matrix_a_re, matrix_b_re, matrix_c_we,
         row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c, data_out_c};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL %s outputs=%0h required=0", name, v);
    end else begin
      $display("%s outputs all zero", name);
    end
    tick();
  endtask

  // Wait (bounded) for the scoreboard to empty, then a few quiet cycles.
  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    repeat (4) tick();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic push_full_run(input logic [RW-1:0] c00, c01, c10, c11);
    push(EV_WRITE, 0, 0, c00);
    push(EV_WRITE, 0, 1, c01);
    push(EV_WRITE, 1, 0, c10);
    push(EV_WRITE, 1, 1, c11);
    push(EV_DONE, 0, 0, '0);
  endtask

  initial begin
    int busy_cnt;
    load(1, 2, 3, 4, 5, 6, 7, 8);

    // Reset, then five idle cycles with no activity
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) check_idle("reset_idle");

    // Full run: 19 22 43 50, busy 12 cycles, one done
    push_full_run(19, 22, 43, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != 12) begin
      failures++;
      $display("FAIL busy_cycles actual=%0d required=12", busy_cnt);
    end else begin
      $display("busy_cycles=%0d", busy_cnt);
    end
    drain("full_run");

    // Stop in the 2nd MAC cycle of element (1,0)
    push(EV_WRITE, 0, 0, 19);
    push(EV_WRITE, 0, 1, 22);
    push(EV_STOPPED, 0, 0, '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain("stop_mac");
    check_idle("after_stop_mac");

    // Stop coincident with the WRITE of (0,0)
    push(EV_WRITE, 0, 0, 19);
    push(EV_STOPPED, 0, 0, '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain("stop_write");
    check_idle("after_stop_write");

    // Start and stop together in IDLE: nothing happens
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check_idle("start_stop_same");
    drain("start_stop_same");

    // Start held while busy is ignored; run completes once
    push_full_run(19, 22, 43, 50);
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    drain("start_while_busy");

    // Reset mid-run: only (0,0) gets written, no pulse
    push(EV_WRITE, 0, 0, 19);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("after_mid_reset");
    drain("mid_reset");

    // Fresh run after reset; operands with top bit set
`ifdef MAC_STOP_SEQ_SIGNED_EN
    load(32'hFFFF_FFFF, 2, 3, 32'hFFFF_FFFC, 1, 0, 0, 1);
    push_full_run(RW'(-1), 2, 3, RW'(-4));
`else
    load(32'hFFFF_FFFF, 2, 3, 32'hFFFF_FFFC, 1, 0, 0, 1);
    push_full_run(RW'(64'h0000_0000_FFFF_FFFF), 2, 3, RW'(64'h0000_0000_FFFF_FFFC));
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("operand_msb");

    // Large operands: (2^32-1)^2 summed twice needs the extra result bit
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
`ifdef MAC_STOP_SEQ_SIGNED_EN
    push_full_run(2, 0, 0, 0);
`else
    push_full_run({1'b1, 64'hFFFF_FFFC_0000_0002}, 0, 0, 0);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("wide_acc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
